// File: rtl/shift_sequencer.sv
// Two-requester job sequencer that drives an external 8-bit shift register: load, shift N times, respond.
// Optional SHIFT_SEQ_RR_ARB_EN selects round-robin tie-breaking; otherwise req0 has fixed priority.
module shift_sequencer (
  input  logic       clk,
  input  logic       reset,
  input  logic       req0_valid,
  output logic       req0_ready,
  input  logic [7:0] req0_data,
  input  logic       req0_dir,
  input  logic [3:0] req0_count,
  input  logic       req1_valid,
  output logic       req1_ready,
  input  logic [7:0] req1_data,
  input  logic       req1_dir,
  input  logic [3:0] req1_count,
  output logic       sr_load,
  output logic       sr_shift_en,
  output logic       sr_dir,
  output logic [7:0] sr_in,
  input  logic [7:0] sr_out,
  output logic       rsp_valid,
  input  logic       rsp_ready,
  output logic [7:0] rsp_data,
  output logic       rsp_id,
  output logic       busy
);

  typedef enum logic [1:0] {IDLE, LOAD, SHIFT, RESP} state_t;

  state_t     state;
  logic [3:0] remain;
  logic       id_q;

  logic       gnt0;
  logic       gnt1;
  logic       accept;
  logic       acc_id;
  logic [7:0] acc_data;
  logic       acc_dir;
  logic [3:0] acc_count;
  logic [3:0] acc_clamped;

`ifdef SHIFT_SEQ_RR_ARB_EN
  // High when req1 should win the next tie; cleared so req0 wins the first tie after reset.
  logic prio1;
`endif

  // NOTE: every signal gets a default at the top of always_comb so no path leaves it unassigned (no latch).
  always_comb begin
    gnt0        = 1'b0;
    gnt1        = 1'b0;
    req0_ready  = 1'b0;
    req1_ready  = 1'b0;
    acc_data    = '0;
    acc_dir     = 1'b0;
    acc_count   = '0;
    acc_clamped = '0;
    rsp_data    = '0;

`ifdef SHIFT_SEQ_RR_ARB_EN
    gnt0 = req0_valid && !(req1_valid && prio1);
`else
    gnt0 = req0_valid;
`endif
    gnt1 = req1_valid && !gnt0;

    // Ready is masked by reset so every output reads 0 while reset is held.
    if (state == IDLE && !reset) begin
      req0_ready = gnt0;
      req1_ready = gnt1;
    end

    if (req1_ready) begin
      acc_data  = req1_data;
      acc_dir   = req1_dir;
      acc_count = req1_count;
    end else begin
      acc_data  = req0_data;
      acc_dir   = req0_dir;
      acc_count = req0_count;
    end
    acc_clamped = (acc_count > 4'd8) ? 4'd8 : acc_count;

    if (state == RESP) rsp_data = sr_out;
  end

  assign accept = req0_ready || req1_ready;
  assign acc_id = req1_ready;

  // NOTE: state and registered outputs use non-blocking assignments so all flops update together on the edge.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state       <= IDLE;
      remain      <= '0;
      id_q        <= 1'b0;
      sr_load     <= 1'b0;
      sr_shift_en <= 1'b0;
      sr_dir      <= 1'b0;
      sr_in       <= '0;
      rsp_valid   <= 1'b0;
      rsp_id      <= 1'b0;
      busy        <= 1'b0;
`ifdef SHIFT_SEQ_RR_ARB_EN
      prio1       <= 1'b0;
`endif
    end else begin
      case (state)
        IDLE: begin
          if (accept) begin
            state   <= LOAD;
            remain  <= acc_clamped;
            id_q    <= acc_id;
            sr_load <= 1'b1;
            sr_in   <= acc_data;
            sr_dir  <= acc_dir;
            busy    <= 1'b1;
`ifdef SHIFT_SEQ_RR_ARB_EN
            prio1   <= !acc_id;
`endif
          end
        end
        LOAD: begin
          sr_load <= 1'b0;
          sr_in   <= '0;
          if (remain != 4'd0) begin
            state       <= SHIFT;
            sr_shift_en <= 1'b1;
          end else begin
            state     <= RESP;
            rsp_valid <= 1'b1;
            rsp_id    <= id_q;
          end
        end
        SHIFT: begin
          remain <= remain - 4'd1;
          if (remain == 4'd1) begin
            state       <= RESP;
            sr_shift_en <= 1'b0;
            rsp_valid   <= 1'b1;
            rsp_id      <= id_q;
          end
        end
        RESP: begin
          if (rsp_ready) begin
            state     <= IDLE;
            rsp_valid <= 1'b0;
            rsp_id    <= 1'b0;
            sr_dir    <= 1'b0;
            busy      <= 1'b0;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
